aq_sysio_top: RTL and testbench

System-side counterpart of the core IO boundary. Synchronizes the six pad interrupt lines into the core clock domain. Captures the reset base address while reset is held. Consumes the core's low-power-mode request (`cpuio_sysio_lpmd_b`) and runs the clock-off/wake handshake with the clock generator. It sits outside the core, between pads/clkgen and the core IO wrapper, on the always-on clock.

---
 rtl/aq_sysio_top.sv | 226 ++++++++++++++++++++++
 tb/tb_aq_sysio_top.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/aq_sysio_top.sv
// -----------------------------------------------------------------------------
// aq_sysio_top
//   System-side companion of the core IO boundary, clocked by the always-on
//   core clock.  It does three jobs:
//     * brings the six asynchronous pad interrupt levels into the core clock
//       domain (plain two-flop synchronizers, no filtering);
//     * captures the reset vector base address while reset is held;
//     * turns the core's low-power request into the clock-off / wake handshake
//       with the clock generator.
//
// Ports
//   forever_cpuclk            in   always-on core clock
//   cpurst                    in   synchronous active-high reset
//   pad_cpu_{me,ms,mt,se,ss,st}_int  in  asynchronous level interrupts
//   pad_cpu_rvba[39:0]        in   reset vector base from pads
//   cpuio_sysio_lpmd_b[1:0]   in   core low-power request (11 RUN, 00 WAIT,
//                                  01 DOZE, 10 STOP)
//   clkgen_sysio_clkoff_ack   in   clkgen reports core clock gated (1) / on (0)
//   sysio_cpuio_*_int         out  synchronized interrupts
//   sysio_xx_rvba[39:0]       out  latched reset base address
//   sysio_clkgen_clkoff_req   out  request to gate the core clock
//   sysio_pad_lpmd_b[1:0]     out  low-power status to pads, 11 unless the
//                                  clock is confirmed off
// -----------------------------------------------------------------------------

// Single-bit two-flop synchronizer; the second flop drives the output.
module aq_sysio_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

module aq_sysio_top #(
    parameter int ENTER_DLY = 4   // stable cycles before clock-off, 1..15
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        pad_cpu_me_int,
    input  logic        pad_cpu_ms_int,
    input  logic        pad_cpu_mt_int,
    input  logic        pad_cpu_se_int,
    input  logic        pad_cpu_ss_int,
    input  logic        pad_cpu_st_int,
    input  logic [39:0] pad_cpu_rvba,
    input  logic [1:0]  cpuio_sysio_lpmd_b,
    input  logic        clkgen_sysio_clkoff_ack,
    output logic        sysio_cpuio_me_int,
    output logic        sysio_cpuio_ms_int,
    output logic        sysio_cpuio_mt_int,
    output logic        sysio_cpuio_se_int,
    output logic        sysio_cpuio_ss_int,
    output logic        sysio_cpuio_st_int,
    output logic [39:0] sysio_xx_rvba,
    output logic        sysio_clkgen_clkoff_req,
    output logic [1:0]  sysio_pad_lpmd_b
);

    localparam int         NUM_INT   = 6;
    localparam logic [3:0] DLY       = 4'(ENTER_DLY);
    localparam logic [1:0] LPMD_RUN  = 2'b11;
    localparam logic [1:0] LPMD_STOP = 2'b10;

    // Interrupt vector bit positions.
    localparam int I_ME = 5;
    localparam int I_SE = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ENTER = 2'd1,
        ST_OFF   = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // Interrupt synchronizers
    // -------------------------------------------------------------------------
    logic [NUM_INT-1:0] pad_int;
    logic [NUM_INT-1:0] int_sync;

    assign pad_int = {pad_cpu_me_int, pad_cpu_ms_int, pad_cpu_mt_int,
                      pad_cpu_se_int, pad_cpu_ss_int, pad_cpu_st_int};

    for (genvar i = 0; i < NUM_INT; i++) begin : g_sync
        aq_sysio_sync u_sync (
            .clk_i (forever_cpuclk),
            .rst_i (cpurst),
            .d_i   (pad_int[i]),
            .q_o   (int_sync[i])
        );
    end

    assign sysio_cpuio_me_int = int_sync[5];
    assign sysio_cpuio_ms_int = int_sync[4];
    assign sysio_cpuio_mt_int = int_sync[3];
    assign sysio_cpuio_se_int = int_sync[2];
    assign sysio_cpuio_ss_int = int_sync[1];
    assign sysio_cpuio_st_int = int_sync[0];

    // -------------------------------------------------------------------------
    // Reset vector base: transparent while in reset, frozen afterwards.
    // -------------------------------------------------------------------------
    logic [39:0] rvba_q;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            rvba_q <= pad_cpu_rvba;
        end
    end

    assign sysio_xx_rvba = rvba_q;

    // -------------------------------------------------------------------------
    // Wake event, qualified by the latched low-power mode.  STOP only wakes
    // on external interrupts; WAIT and DOZE wake on anything.
    // -------------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  pad_lpmd_q, pad_lpmd_d;
    logic        clkoff_q, clkoff_d;
    logic        wake_evt;

    always_comb begin
        wake_evt = |int_sync;
        if (mode_q == LPMD_STOP) begin
            wake_evt = int_sync[I_ME] | int_sync[I_SE];
        end
    end

    // -------------------------------------------------------------------------
    // Low-power handshake FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        pad_lpmd_d = LPMD_RUN;

        case (state_q)
            ST_RUN: begin
                if (cpuio_sysio_lpmd_b != LPMD_RUN) begin
                    state_d = ST_ENTER;
                    mode_d  = cpuio_sysio_lpmd_b;
                    cnt_d   = DLY;
                end
            end

            ST_ENTER: begin
                // Wake outranks an expiring counter so a late interrupt never
                // lets the clock go off.
                if (cpuio_sysio_lpmd_b == LPMD_RUN || wake_evt) begin
                    state_d = ST_RUN;
                end else if (cpuio_sysio_lpmd_b != mode_q) begin
                    // Request changed flavour: restart the stability window.
                    cnt_d  = DLY;
                    mode_d = cpuio_sysio_lpmd_b;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_OFF;
                    end
                end
            end

            ST_OFF: begin
                // lpmd_b is ignored here; only a wake gets us out.  The pad
                // status follows ack so a clkgen abort reverts it to RUN.
                if (wake_evt) begin
                    state_d = ST_WAKE;
                end else if (clkgen_sysio_clkoff_ack) begin
                    pad_lpmd_d = mode_q;
                end
            end

            ST_WAKE: begin
                // Wait for the clock to be restored and the core to be back
                // in RUN; no timeout.
                if (!clkgen_sysio_clkoff_ack && cpuio_sysio_lpmd_b == LPMD_RUN) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        clkoff_d = (state_d == ST_OFF);
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q    <= ST_RUN;
            cnt_q      <= 4'd0;
            mode_q     <= LPMD_RUN;
            pad_lpmd_q <= LPMD_RUN;
            clkoff_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            pad_lpmd_q <= pad_lpmd_d;
            clkoff_q   <= clkoff_d;
        end
    end

    assign sysio_clkgen_clkoff_req = clkoff_q;
    assign sysio_pad_lpmd_b        = pad_lpmd_q;

endmodule

// File: tb/tb_aq_sysio_top.sv
// -----------------------------------------------------------------------------
// tb_aq_sysio_top
//   Directed bench for aq_sysio_top (ENTER_DLY = 4).  Inputs are driven 1 ns
//   after each rising edge and outputs are checked at the same point, so each
//   check observes the state produced by the edge just taken.
// -----------------------------------------------------------------------------
module tb_aq_sysio_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        me, ms, mt, se, ss, st;
    logic [39:0] rvba_pad;
    logic [1:0]  lpmd;
    logic        ack;

    logic        o_me, o_ms, o_mt, o_se, o_ss, o_st;
    logic [39:0] o_rvba;
    logic        o_req;
    logic [1:0]  o_lpmd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    aq_sysio_top #(.ENTER_DLY(4)) dut (
        .forever_cpuclk          (clk),
        .cpurst                  (rst),
        .pad_cpu_me_int          (me),
        .pad_cpu_ms_int          (ms),
        .pad_cpu_mt_int          (mt),
        .pad_cpu_se_int          (se),
        .pad_cpu_ss_int          (ss),
        .pad_cpu_st_int          (st),
        .pad_cpu_rvba            (rvba_pad),
        .cpuio_sysio_lpmd_b      (lpmd),
        .clkgen_sysio_clkoff_ack (ack),
        .sysio_cpuio_me_int      (o_me),
        .sysio_cpuio_ms_int      (o_ms),
        .sysio_cpuio_mt_int      (o_mt),
        .sysio_cpuio_se_int      (o_se),
        .sysio_cpuio_ss_int      (o_ss),
        .sysio_cpuio_st_int      (o_st),
        .sysio_xx_rvba           (o_rvba),
        .sysio_clkgen_clkoff_req (o_req),
        .sysio_pad_lpmd_b        (o_lpmd)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] all_int;
    assign all_int = {o_me, o_ms, o_mt, o_se, o_ss, o_st};

    initial begin
        rst = 1'b1; rvba_pad = 40'h00_8000_0000; lpmd = 2'b11; ack = 1'b0;
        {me, ms, mt, se, ss, st} = 6'b0;

        // ---------------- reset / RVBA ----------------
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_int",  64'(all_int), 64'h0);
            chk("rst_req",  64'(o_req),   64'h0);
            chk("rst_lpmd", 64'(o_lpmd),  64'h3);
            chk("rst_rvba", 64'(o_rvba),  64'h00_8000_0000);
        end
        rst = 1'b0;
        tick();
        rvba_pad = 40'h12_3456_7890;
        tick();
        chk("rvba_hold1", 64'(o_rvba), 64'h00_8000_0000);
        tick();
        chk("rvba_hold2", 64'(o_rvba), 64'h00_8000_0000);

        // ---------------- interrupt sync: mt high 3 cycles ----------------
        mt = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 3) mt = 1'b0;
            chk($sformatf("mt_sync_%0d", i), 64'(o_mt), 64'((i >= 2 && i <= 4) ? 1 : 0));
            chk($sformatf("mt_other_%0d", i), 64'(all_int & 6'b110111), 64'h0);
        end

        // ---------------- WAIT entry / exit ----------------
        lpmd = 2'b00;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("wait_req_%0d", i), 64'(o_req), 64'((i == 5) ? 1 : 0));
        end
        chk("wait_lpmd_noack", 64'(o_lpmd), 64'h3);
        ack = 1'b1;
        tick();
        chk("wait_lpmd_ack", 64'(o_lpmd), 64'h0);
        chk("wait_req_ack",  64'(o_req),  64'h1);
        ss = 1'b1;
        tick(); chk("wait_wake_e1", 64'(o_req), 64'h1);
        tick(); chk("wait_wake_e2", 64'(o_req), 64'h1);
        chk("wait_ss_sync", 64'(o_ss), 64'h1);
        tick(); chk("wait_wake_e3", 64'(o_req), 64'h0);
        chk("wait_wake_lpmd", 64'(o_lpmd), 64'h3);
        // Still in WAKE while ack stays high.
        ss = 1'b0; lpmd = 2'b11;
        tick(); tick();
        chk("wake_hold_req",  64'(o_req),  64'h0);
        chk("wake_hold_lpmd", 64'(o_lpmd), 64'h3);
        ack = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("wait_exit_lpmd", 64'(o_lpmd), 64'h3);
        chk("wait_exit_req",  64'(o_req),  64'h0);

        // ---------------- STOP filtering ----------------
        lpmd = 2'b10;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("stop_req_%0d", i), 64'(o_req), 64'((i == 5) ? 1 : 0));
        end
        ack = 1'b1;
        tick();
        chk("stop_lpmd_ack", 64'(o_lpmd), 64'h2);
        mt = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("stop_mt_nowake_%0d", i), 64'(o_req), 64'h1);
        end
        chk("stop_mt_synced", 64'(o_mt), 64'h1);
        chk("stop_lpmd_hold", 64'(o_lpmd), 64'h2);
        me = 1'b1;
        tick(); chk("stop_me_e1", 64'(o_req), 64'h1);
        tick(); chk("stop_me_e2", 64'(o_req), 64'h1);
        tick(); chk("stop_me_e3", 64'(o_req), 64'h0);
        chk("stop_me_lpmd", 64'(o_lpmd), 64'h3);
        me = 1'b0; mt = 1'b0; ack = 1'b0; lpmd = 2'b11;
        for (int i = 0; i < 4; i++) tick();

        // ---------------- restart in ENTER: 00 then 01 ----------------
        lpmd = 2'b00;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 2) lpmd = 2'b01;
            chk($sformatf("restart_req_%0d", i), 64'(o_req), 64'((i == 7) ? 1 : 0));
        end
        ack = 1'b1;
        tick();
        chk("restart_lpmd", 64'(o_lpmd), 64'h1);
        st = 1'b1;   // DOZE wakes on any interrupt
        tick(); tick(); tick();
        chk("doze_st_wake", 64'(o_req), 64'h0);
        st = 1'b0; ack = 1'b0; lpmd = 2'b11;
        for (int i = 0; i < 4; i++) tick();

        // ---------------- interrupt on the expiring ENTER cycle ----------------
        lpmd = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 2) ms = 1'b1;
            chk($sformatf("expire_req_%0d", i), 64'(o_req), 64'h0);
        end
        ms = 1'b0; lpmd = 2'b11;
        for (int i = 0; i < 4; i++) tick();

        // ---------------- ack drop in OFF, then reset mid-OFF ----------------
        lpmd = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_off_req", 64'(o_req), 64'h1);
        ack = 1'b1;
        tick();
        chk("abort_lpmd_on", 64'(o_lpmd), 64'h0);
        ack = 1'b0;
        tick();
        chk("abort_lpmd_rev", 64'(o_lpmd), 64'h3);
        chk("abort_req_stay", 64'(o_req),  64'h1);
        ack = 1'b1;
        tick();
        chk("abort_lpmd_again", 64'(o_lpmd), 64'h0);
        rst = 1'b1;
        tick();
        chk("rstoff_req",  64'(o_req),  64'h0);
        chk("rstoff_lpmd", 64'(o_lpmd), 64'h3);
        chk("rstoff_rvba", 64'(o_rvba), 64'h12_3456_7890);
        rst = 1'b0; ack = 1'b0; lpmd = 2'b11;
        for (int i = 0; i < 3; i++) tick();
        chk("rstoff_run_req", 64'(o_req), 64'h0);
        // Back in RUN: a fresh request must reach OFF after the full delay.
        lpmd = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("rstoff_reenter_%0d", i), 64'(o_req), 64'((i == 5) ? 1 : 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
